// File: rtl/pcu_pkg.sv
// Shared definitions for the PC control unit: opcodes, link/status register
// numbers and the fetch FSM state type.
package pcu_pkg;

    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] REG_LINK   = 5'd31;
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pcu_state_e;

    // Opcode field of an instruction word
    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        return instr[31:27];
    endfunction

endpackage

// File: rtl/pcu_next_pc.sv
// Combinational next-PC selection for j/jal/jr/bne/blt/bex; everything else
// falls through to PC+1. Also reports whether the flow left the sequential path.
module pcu_next_pc #(
    parameter int unsigned PC_W = 32
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [31:0]     i_instr,
    input  logic [31:0]     i_rega,
    input  logic            i_cmp_ne,
    input  logic            i_cmp_lt,
    output logic [PC_W-1:0] o_next_pc,
    output logic [PC_W-1:0] o_pc_inc,
    output logic            o_taken
);
    import pcu_pkg::*;

    logic [4:0]      w_opcode;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_branch;

    assign w_opcode = get_opcode(i_instr);
    assign w_target = PC_W'({5'b0, i_instr[26:0]});
    // Sign-extend the 17-bit immediate to the PC width
    assign w_offset = PC_W'($signed(i_instr[16:0]));
    assign o_pc_inc = i_pc + PC_W'(1);
    assign w_branch = o_pc_inc + w_offset;

    // Pick the next PC from the decoded opcode
    always_comb begin
        o_next_pc = o_pc_inc;
        case (w_opcode)
            OP_J, OP_JAL: o_next_pc = w_target;
            OP_JR:        o_next_pc = PC_W'(i_rega);
            OP_BNE:       o_next_pc = i_cmp_ne ? w_branch : o_pc_inc;
            OP_BLT:       o_next_pc = i_cmp_lt ? w_branch : o_pc_inc;
            OP_BEX:       o_next_pc = (i_rega != 32'd0) ? w_target : o_pc_inc;
            default:      o_next_pc = o_pc_inc;
        endcase
    end

    assign o_taken = (o_next_pc != o_pc_inc);

endmodule

// File: rtl/pc_control_unit.sv
// Fetch-side control-flow engine: owns the PC, runs the BOOT/RUN/HALT FSM and
// drives the r31 link / r30 status writes.
// Optional feature macro: PCU_PERF_CNT_EN adds saturating retired/taken counters.
module pc_control_unit #(
    parameter int unsigned    PC_W     = 32,
    parameter int unsigned    IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        q_imem,
    input  logic               stall,
    input  logic [31:0]        data_readRegA,
    input  logic               cmp_ne,
    input  logic               cmp_lt,
    output logic [IMEM_AW-1:0] address_imem,
    output logic [4:0]         ctrl_readRegA,
    output logic               cf_we,
    output logic [4:0]         cf_wreg,
    output logic [31:0]        cf_wdata,
    output logic               halted,
    output logic [PC_W-1:0]    pc_full
`ifdef PCU_PERF_CNT_EN
    ,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        taken_cnt
`endif
);
    import pcu_pkg::*;

    pcu_state_e      r_state;
    pcu_state_e      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_taken;
    logic [4:0]      w_opcode;
    logic            w_active;
    logic            w_halt_hit;

    assign w_opcode = get_opcode(q_imem);
    // An instruction only takes effect in RUN without a stall
    assign w_active = (r_state == StRun) && !stall;
    // A j onto its own address is the program's halt idiom
    assign w_halt_hit = w_active && (w_opcode == OP_J) &&
                        (PC_W'({5'b0, q_imem[26:0]}) == r_pc);

    pcu_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .i_pc      (r_pc),
        .i_instr   (q_imem),
        .i_rega    (data_readRegA),
        .i_cmp_ne  (cmp_ne),
        .i_cmp_lt  (cmp_lt),
        .o_next_pc (w_next_pc),
        .o_pc_inc  (w_pc_inc),
        .o_taken   (w_taken)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: BOOT spends one cycle covering imem read latency
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   w_state_next = w_halt_hit ? StHalt : StRun;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StBoot;
        endcase
    end

    // PC register: advances only on an active cycle, frozen otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_active) begin
            r_pc <= w_next_pc;
        end
    end

    // FSM outputs: link/status writes are gated by the active condition
    always_comb begin
        cf_we    = 1'b0;
        cf_wreg  = 5'd0;
        cf_wdata = 32'd0;
        if (w_active && (w_opcode == OP_JAL)) begin
            cf_we    = 1'b1;
            cf_wreg  = REG_LINK;
            cf_wdata = 32'(w_pc_inc);
        end else if (w_active && (w_opcode == OP_SETX)) begin
            cf_we    = 1'b1;
            cf_wreg  = REG_STATUS;
            cf_wdata = {5'b0, q_imem[26:0]};
        end
        halted = (r_state == StHalt);
    end

    assign ctrl_readRegA = (w_opcode == OP_BEX) ? REG_STATUS : q_imem[26:22];
    assign address_imem  = r_pc[IMEM_AW-1:0];
    assign pc_full       = r_pc;

`ifdef PCU_PERF_CNT_EN
    logic [31:0] r_retired;
    logic [31:0] r_taken;

    // Saturating counters of executed instructions and non-sequential flow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
            r_taken   <= 32'd0;
        end else if (w_active) begin
            if (r_retired != '1) begin
                r_retired <= r_retired + 32'd1;
            end
            if (w_taken && (r_taken != '1)) begin
                r_taken <= r_taken + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired;
    assign taken_cnt   = r_taken;
`endif

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench for pc_control_unit: directed scenarios with literal
// expectations followed by random instruction streams against a reference model.
module tb_pc_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] q_imem = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] data_readRegA = 32'd0;
    logic        cmp_ne = 1'b0;
    logic        cmp_lt = 1'b0;
    logic [11:0] address_imem;
    logic [4:0]  ctrl_readRegA;
    logic        cf_we;
    logic [4:0]  cf_wreg;
    logic [31:0] cf_wdata;
    logic        halted;
    logic [31:0] pc_full;
`ifdef PCU_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;
`endif

    pc_control_unit #(
        .PC_W     (32),
        .IMEM_AW  (12),
        .RESET_PC (32'd0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .q_imem        (q_imem),
        .stall         (stall),
        .data_readRegA (data_readRegA),
        .cmp_ne        (cmp_ne),
        .cmp_lt        (cmp_lt),
        .address_imem  (address_imem),
        .ctrl_readRegA (ctrl_readRegA),
        .cf_we         (cf_we),
        .cf_wreg       (cf_wreg),
        .cf_wdata      (cf_wdata),
        .halted        (halted),
        .pc_full       (pc_full)
`ifdef PCU_PERF_CNT_EN
        ,
        .retired_cnt   (retired_cnt),
        .taken_cnt     (taken_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [26:0] imm);
        return {op, imm};
    endfunction

    // Reference next-PC straight from the instruction-set rules
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic [31:0] a, input logic ne,
                                             input logic lt);
        logic [31:0] t;
        logic [31:0] n;
        logic [31:0] seq;
        t   = instr & 32'h07ff_ffff;
        n   = {{15{instr[16]}}, instr[16:0]};
        seq = pc + 32'd1;
        case (instr[31:27])
            5'b00001, 5'b00011: return t;
            5'b00100:           return a;
            5'b00010:           return ne ? seq + n : seq;
            5'b00110:           return lt ? seq + n : seq;
            5'b10110:           return (a != 32'd0) ? t : seq;
            default:            return seq;
        endcase
    endfunction

    // Model state: PC, and whether the unit is running / halted (neither = boot)
    logic [31:0] m_pc = 32'd0;
    logic        m_run = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_ret = 32'd0;
    logic [31:0] m_tak = 32'd0;
    logic [31:0] m_nxt;

    always_comb m_nxt = ref_next(m_pc, q_imem, data_readRegA, cmp_ne, cmp_lt);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc   <= 32'd0;
            m_run  <= 1'b0;
            m_halt <= 1'b0;
            m_ret  <= 32'd0;
            m_tak  <= 32'd0;
        end else if (!m_run && !m_halt) begin
            m_run <= 1'b1;
        end else if (m_run && !stall) begin
            if (q_imem[31:27] == 5'b00001 && m_nxt == m_pc) begin
                m_run  <= 1'b0;
                m_halt <= 1'b1;
            end
            m_pc <= m_nxt;
            if (m_ret != 32'hffff_ffff) m_ret <= m_ret + 32'd1;
            if (m_nxt != m_pc + 32'd1 && m_tak != 32'hffff_ffff) m_tak <= m_tak + 32'd1;
        end
    end

    // Expected combinational outputs for the current instruction
    logic        e_act;
    logic        e_we;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic [4:0]  e_ctrl;

    always_comb begin
        e_act   = m_run && !stall && !reset;
        e_we    = 1'b0;
        e_wreg  = 5'd0;
        e_wdata = 32'd0;
        if (e_act && q_imem[31:27] == 5'b00011) begin
            e_we    = 1'b1;
            e_wreg  = 5'd31;
            e_wdata = m_pc + 32'd1;
        end else if (e_act && q_imem[31:27] == 5'b10101) begin
            e_we    = 1'b1;
            e_wreg  = 5'd30;
            e_wdata = {5'b0, q_imem[26:0]};
        end
        e_ctrl = (q_imem[31:27] == 5'b10110) ? 5'd30 : q_imem[26:22];
    end

    // Compare every cycle, away from the active edge
    always @(negedge clock) begin
        check("address_imem", 32'(address_imem), 32'(m_pc[11:0]));
        check("pc_full", pc_full, m_pc);
        check("halted", 32'(halted), 32'(m_halt));
        check("cf_we", 32'(cf_we), 32'(e_we));
        check("cf_wreg", 32'(cf_wreg), 32'(e_wreg));
        check("cf_wdata", cf_wdata, e_wdata);
        check("ctrl_readRegA", 32'(ctrl_readRegA), 32'(e_ctrl));
`ifdef PCU_PERF_CNT_EN
        check("retired_cnt", retired_cnt, m_ret);
        check("taken_cnt", taken_cnt, m_tak);
`endif
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic ne,
                         input logic lt, input logic st);
        @(posedge clock);
        #1;
        q_imem        = instr;
        data_readRegA = a;
        cmp_ne        = ne;
        cmp_lt        = lt;
        stall         = st;
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        reset  = 1'b1;
        q_imem = 32'd0;
        stall  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        logic [4:0] ops [10];
        ops = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00110,
                5'b10101, 5'b10110, 5'b00000, 5'b01001, 5'b11111};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        q_imem = mk(5'b00011, 27'd10);
        #1;
        // BOOT: jal presented but must not write
        check("boot_addr", 32'(address_imem), 32'd0);
        check("boot_pc", pc_full, 32'd0);
        check("boot_we", 32'(cf_we), 32'd0);
        check("boot_halted", 32'(halted), 32'd0);

        drive(NOP, 0, 0, 0, 0);
        check("seq0", 32'(address_imem), 32'd0);
        drive(NOP, 0, 0, 0, 0);
        check("seq1", 32'(address_imem), 32'd1);
        drive(NOP, 0, 0, 0, 0);
        check("seq2", 32'(address_imem), 32'd2);
        drive(mk(5'b00011, 27'd10), 0, 0, 0, 0);
        check("seq3", 32'(address_imem), 32'd3);
        check("jal_we", 32'(cf_we), 32'd1);
        check("jal_wreg", 32'(cf_wreg), 32'd31);
        check("jal_wdata", cf_wdata, 32'd4);
        drive(mk(5'b00100, 27'd0), 32'h4, 0, 0, 0);
        check("jal_target", 32'(address_imem), 32'd10);
        drive(NOP, 0, 0, 0, 0);
        check("jr_target", 32'(address_imem), 32'd4);
        drive(NOP, 0, 0, 0, 0);
        drive(mk(5'b10101, 27'd7), 0, 0, 0, 1);
        check("stall_pc_a", 32'(address_imem), 32'd6);
        check("stall_we", 32'(cf_we), 32'd0);
        drive(mk(5'b10101, 27'd7), 0, 0, 0, 1);
        drive(mk(5'b10101, 27'd7), 0, 0, 0, 1);
        check("stall_pc_c", 32'(address_imem), 32'd6);
        drive(NOP, 0, 0, 0, 0);
        check("stall_pc_held", 32'(address_imem), 32'd6);
        drive(mk(5'b00010, 27'h001_fffd), 0, 1, 0, 0);
        check("bne_at", 32'(address_imem), 32'd7);
        drive(NOP, 0, 0, 0, 0);
        check("bne_taken", 32'(address_imem), 32'd5);
        drive(NOP, 0, 0, 0, 0);
        drive(mk(5'b00010, 27'h001_fffd), 0, 0, 0, 0);
        drive(mk(5'b10101, 27'd5), 0, 0, 0, 0);
        check("bne_not_taken", 32'(address_imem), 32'd8);
        check("setx_wreg", 32'(cf_wreg), 32'd30);
        check("setx_wdata", cf_wdata, 32'd5);
        drive(mk(5'b10110, 27'd20), 32'd5, 0, 0, 0);
        check("bex_ctrl_a", 32'(ctrl_readRegA), 32'd30);
        drive(mk(5'b10110, 27'd20), 32'd0, 0, 0, 0);
        check("bex_taken", 32'(address_imem), 32'd20);
        check("bex_ctrl_b", 32'(ctrl_readRegA), 32'd30);
        drive(mk(5'b00001, 27'd24), 0, 0, 0, 0);
        check("bex_not_taken", 32'(address_imem), 32'd21);
        drive(mk(5'b00001, 27'd24), 0, 0, 0, 0);
        check("j_target", 32'(address_imem), 32'd24);
        check("not_yet_halted", 32'(halted), 32'd0);
        drive(NOP, 0, 0, 0, 0);
        check("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(mk(5'b00011, 27'd10), 0, 0, 0, 0);
            check("halt_pc", 32'(address_imem), 32'd24);
            check("halt_we", 32'(cf_we), 32'd0);
        end

        // Asynchronous reset in the middle of a jal
        pulse_reset();
        drive(NOP, 0, 0, 0, 0);
        drive(mk(5'b00011, 27'd10), 0, 0, 0, 0);
        check("midjal_we", 32'(cf_we), 32'd1);
        check("midjal_wdata", cf_wdata, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_we", 32'(cf_we), 32'd0);
        check("rst_pc", pc_full, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        q_imem = NOP;
        #1;

        // PC wrap and far jumps
        drive(mk(5'b00100, 27'd0), 32'hffff_ffff, 0, 0, 0);
        drive(NOP, 0, 0, 0, 0);
        check("wrap_pc_top", pc_full, 32'hffff_ffff);
        check("wrap_addr_top", 32'(address_imem), 32'hfff);
        drive(NOP, 0, 0, 0, 0);
        check("wrap_pc_zero", pc_full, 32'd0);
        drive(mk(5'b00100, 27'd0), 32'h0000_0fff, 0, 0, 0);
        drive(mk(5'b00001, 27'd0), 0, 0, 0, 0);
        check("far_pc", pc_full, 32'h0000_0fff);
        drive(NOP, 0, 0, 0, 0);
        check("j0_pc", pc_full, 32'd0);
`ifdef PCU_PERF_CNT_EN
        check("taken_lit", taken_cnt, 32'd3);
        check("retired_lit", retired_cnt, 32'd5);
`endif

        // Random instruction streams
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  op;
            logic [26:0] imm;
            logic [31:0] a;
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                pulse_reset();
            end
            op  = ops[$urandom_range(0, 9)];
            imm = ($urandom_range(0, 1) == 0) ? 27'($urandom_range(0, 40)) : 27'($urandom);
            case ($urandom_range(0, 2))
                0:       a = 32'd0;
                1:       a = 32'($urandom_range(0, 40));
                default: a = $urandom;
            endcase
            drive(mk(op, imm), a, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
        end

        @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
Fetch-side control-flow engine for the single-cycle processor. It owns the program counter, drives the instruction-memory address and applies next-PC rules for j, jal, jr, bne, blt, setx and bex. It produces the r31 link and r30 status writes that the processor bench checks on the regfile write port. It sits inside the processor between imem and the regfile/ALU compare outputs, clocked by processor_clock.

Parameters:
PC_W, 32, internal PC register width
IMEM_AW, 12, width of address_imem (low bits of PC)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  processor clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; forces PC=RESET_PC and state=BOOT
q_imem  in  32  instruction word currently fetched at address_imem
stall  in  1  hold PC and suppress all writes this cycle
data_readRegA  in  32  regfile port A data (jr target / r30 status)
cmp_ne  in  1  ALU: rd != rs for the current instruction
cmp_lt  in  1  ALU: signed rd < rs for the current instruction
address_imem  out  IMEM_AW  PC[IMEM_AW-1:0]
ctrl_readRegA  out  5  r30 for bex, rd field [26:22] otherwise
cf_we  out  1  control-flow regfile write enable (jal/setx)
cf_wreg  out  5  31 for jal, 30 for setx, else 0
cf_wdata  out  32  jal: PC+1; setx: zero-extended T; else 0
halted  out  1  high in HALT state
pc_full  out  PC_W  full PC for debug

Behaviour:
- Opcode = q_imem[31:27]; T = {5'b0, q_imem[26:0]}; N = sign-extended q_imem[16:0] to 32 bits.
- FSM states: BOOT, RUN, HALT. Reset -> BOOT with PC=RESET_PC. BOOT -> RUN after one clock, with PC unchanged; this covers the imem read latency. RUN -> HALT when a j instruction targets its own PC (self-loop). HALT exits only on reset.
- Reset values: address_imem=RESET_PC low bits, cf_we=0, cf_wreg=0, cf_wdata=0, halted=0, pc_full=RESET_PC.
- Next PC in RUN with stall=0:
  - j (00001): T
  - jal (00011): T
  - jr (00100): data_readRegA
  - bne (00010): PC+1+N if cmp_ne, else PC+1
  - blt (00110): PC+1+N if cmp_lt, else PC+1
  - bex (10110): T if data_readRegA != 0, else PC+1
  - setx (10101) and all other opcodes: PC+1
- Adds are PC_W-bit modulo, so PC wrap from all-ones to 0 is legal. address_imem truncates to IMEM_AW bits.
- Latency: the new PC appears on address_imem one clock after the instruction is presented.
- cf_we, cf_wreg and cf_wdata are combinational from the current instruction, valid in the same cycle. jal drives cf_wdata = PC+1 (full width). setx drives cf_wdata = T. Both assert cf_we=1.
- cf_we is forced to 0 when stall=1, in BOOT, or in HALT.
- stall=1: PC is held and no write occurs. Stall takes priority over HALT entry.
- In HALT, PC stays frozen and halted=1.
- Reset asserted mid-instruction aborts the pending write immediately, since the path is asynchronous.

Optional Feature:
PCU_PERF_CNT_EN
- Defined: adds outputs retired_cnt[31:0] and taken_cnt[31:0], both reset to 0.
  - retired_cnt increments once per RUN cycle with stall=0.
  - taken_cnt increments when next PC != PC+1.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package pcu_pkg holds:
  - opcode constants OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_SETX, OP_BEX
  - REG_LINK=31 and REG_STATUS=30
  - the FSM state enum
- One sub-module, pcu_next_pc: purely combinational next-PC and taken selection. The top holds the PC register, the FSM and the write outputs.

Test Plan:
- Reset then sequential NOPs: after BOOT, address_imem goes 0,1,2,3 on successive clocks; cf_we stays 0.
- jal T=10 at PC=3: cf_we=1, cf_wreg=31, cf_wdata=4; next address_imem=10.
- jr with data_readRegA=0x00000004 at PC=10 -> next PC=4. bne N=-3 at PC=7 with cmp_ne=1 -> 5; with cmp_ne=0 -> 8.
- setx T=5 -> cf_wreg=30, cf_wdata=5. bex T=20 with A=5 -> PC=20; with A=0 -> PC+1. ctrl_readRegA=30 in both cases.
- j T=24 at PC=24 -> HALT, halted=1, PC frozen at 24 for 10 clocks. stall=1 at PC=6 for 3 clocks -> PC held at 6 and cf_we=0.
- Reset asserted asynchronously mid-jal -> cf_we drops immediately, PC=0, FSM in BOOT. Under PCU_PERF_CNT_EN, a j T=0 at PC=0xFFF... -> taken_cnt+1.
